// File: rtl/axi_w_beat_issuer.sv
// axi_w_beat_issuer: drains a show-ahead write-data FIFO into AXI W-channel
// bursts. Beat counts come from the address path, one command per burst.
// A 2-entry output buffer (head + skid) keeps one beat per cycle flowing
// under a fully registered valid/ready W interface.
module axi_w_beat_issuer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  w_last_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic                  busy_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  head_last_q, head_last_d;
  logic                  skid_last_q, skid_last_d;

  logic pop;
  logic cmd_fire;
  logic xfer;
  logic cnt_zero;

  assign cnt_zero     = (beat_cnt_q == '0);
  // rst_n gating keeps the combinational handshakes quiet during reset.
  assign pop          = rst_n && (state_q == ST_BURST) && !fifo_empty_i && (occ_q != 2'd2);
  assign cmd_ready_o  = rst_n && ((state_q == ST_IDLE) || (pop && cnt_zero));
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign xfer         = (occ_q != 2'd0) && w_ready_i;

  assign fifo_rd_en_o = pop;
  assign w_data_o     = head_data_q;
  assign w_last_o     = head_last_q;
  assign w_valid_o    = (occ_q != 2'd0);
  assign busy_o       = (state_q == ST_BURST) || (occ_q != 2'd0);

  // Burst framing: load the beat count on command accept, count pops down.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ST_IDLE) begin
      if (cmd_fire) begin
        state_d    = ST_BURST;
        beat_cnt_d = cmd_len_i;
      end
    end else if (pop) begin
      if (!cnt_zero) begin
        beat_cnt_d = beat_cnt_q - 1'b1;
      end else if (cmd_fire) begin
        // Next burst chained onto the final pop: stay in BURST, no bubble.
        beat_cnt_d = cmd_len_i;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output buffer: head drives the W channel, skid absorbs one beat of stall.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (occ_q)
      2'd0: begin
        if (pop) begin
          head_data_d = fifo_data_i;
          head_last_d = cnt_zero;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (pop && xfer) begin
          head_data_d = fifo_data_i;
          head_last_d = cnt_zero;
        end else if (pop) begin
          skid_data_d = fifo_data_i;
          skid_last_d = cnt_zero;
          occ_d       = 2'd2;
        end else if (xfer) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: pop is blocked, so only a transfer can change anything.
        if (xfer) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          occ_d       = 2'd1;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

// File: tb/tb_axi_w_beat_issuer.sv
// Directed bench for axi_w_beat_issuer with a queue-based show-ahead FIFO.
module tb_axi_w_beat_issuer;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len_i;
  logic [DW-1:0] w_data_o;
  logic          w_last_o;
  logic          w_valid_o;
  logic          w_ready_i;
  logic          busy_o;

  axi_w_beat_issuer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .w_data_o     (w_data_o),
    .w_last_o     (w_last_o),
    .w_valid_o    (w_valid_o),
    .w_ready_i    (w_ready_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int pops    = 0;

  logic [DW-1:0] fq[$];
  logic [DW:0]   beats[$];

  // Values sampled mid-cycle by the most recent call to cycle().
  logic          s_rd_en, s_cmd_ready, s_valid, s_last, s_busy;
  logic [DW-1:0] s_data;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  function automatic void drive_fifo();
    fifo_empty_i = (fq.size() == 0);
    if (fq.size() != 0) fifo_data_i = fq[0];
    else                fifo_data_i = '0;
  endfunction

  // One clock cycle: sample at negedge, advance the FIFO model after posedge.
  task automatic cycle();
    logic do_pop;
    @(negedge clk);
    s_rd_en     = fifo_rd_en_o;
    s_cmd_ready = cmd_ready_o;
    s_valid     = w_valid_o;
    s_data      = w_data_o;
    s_last      = w_last_o;
    s_busy      = busy_o;
    if (rst_n) begin
      if (fifo_empty_i) begin
        vectors++;
        if (fifo_rd_en_o !== 1'b0) begin
          errors++;
          $display("FAIL pop_while_empty: rd_en=%b required 0 at %0t", fifo_rd_en_o, $time);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (w_valid_o !== 1'b1 || w_data_o !== prev_data || w_last_o !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   w_valid_o, w_data_o, w_last_o, prev_data, prev_last);
        end
      end
      if (fifo_rd_en_o === 1'b1) pops++;
      if (w_valid_o === 1'b1 && w_ready_i === 1'b1) beats.push_back({w_last_o, w_data_o});
      prev_stall = (w_valid_o === 1'b1) && (w_ready_i === 1'b0);
      prev_data  = w_data_o;
      prev_last  = w_last_o;
    end else begin
      prev_stall = 1'b0;
    end
    do_pop = rst_n && (fifo_rd_en_o === 1'b1);
    @(posedge clk);
    #1;
    if (do_pop && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run_until_beats(input int n, input int budget, input string name);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      cycle();
      k++;
    end
    vectors++;
    if (beats.size() != n) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d required %0d", name, beats.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (s_busy !== 1'b0 && k < budget);
    vectors++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0", name, s_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid_i = 1'b1; cmd_len_i = '0; w_ready_i = 1'b1;
    fq.push_back(32'hDEAD_BEEF); drive_fifo();
    cycle(); cycle();
    vectors++;
    if (s_valid !== 1'b0 || s_last !== 1'b0 || s_data !== '0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h b=%b required all 0", s_valid, s_last, s_data, s_busy);
    end
    vectors++;
    if (s_cmd_ready !== 1'b0 || s_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got rdy=%b rd=%b required 0 0", s_cmd_ready, s_rd_en);
    end
    fq.delete(); cmd_valid_i = 1'b0; drive_fifo();
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (s_cmd_ready !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b required 1 0", s_cmd_ready, s_busy);
    end
  endtask

  task automatic test_single();
    int p0;
    beats.delete();
    fq.push_back(32'hA5A5_0001); drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd0; w_ready_i = 1'b1;
    p0 = pops;
    cycle();
    vectors++;
    if (s_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL single_accept: rdy=%b required 1", s_cmd_ready);
    end
    cmd_valid_i = 1'b0;
    cycle();
    vectors++;
    if (s_rd_en !== 1'b1 || s_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop_cycle: rd=%b v=%b required 1 0", s_rd_en, s_valid);
    end
    cycle();
    vectors++;
    if (s_valid !== 1'b1 || s_data !== 32'hA5A5_0001 || s_last !== 1'b1) begin
      errors++; $display("FAIL single_beat: v=%b d=%h l=%b required 1 a5a50001 1", s_valid, s_data, s_last);
    end
    cycle();
    vectors++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL single_done: v=%b b=%b rdy=%b required 0 0 1", s_valid, s_busy, s_cmd_ready);
    end
    vectors++;
    if (pops - p0 !== 1) begin
      errors++; $display("FAIL single_pop_count: got %0d required 1", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    int bad;
    beats.delete();
    for (int i = 0; i < 4; i++) fq.push_back(32'h10 + i);
    drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd3; w_ready_i = 1'b0;
    p0 = pops;
    cycle();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    vectors++;
    if (pops - p0 !== 2) begin
      errors++; $display("FAIL bp_stall_pops: got %0d required 2", pops - p0);
    end
    vectors++;
    if (s_valid !== 1'b1 || s_data !== 32'h10 || s_rd_en !== 1'b0) begin
      errors++; $display("FAIL bp_hold: v=%b d=%h rd=%b required 1 10 0", s_valid, s_data, s_rd_en);
    end
    w_ready_i = 1'b1;
    run_until_beats(4, 20, "bp");
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 3), 32'(32'h10 + i)}) bad++;
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_order: %0d bad beats required 0", bad);
    end
    wait_idle(10, "bp");
  endtask

  task automatic test_starved();
    int bad;
    beats.delete();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd3; w_ready_i = 1'b1;
    cycle();
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(); cycle();
      fq.push_back(32'h30 + k); drive_fifo();
      cycle();
    end
    run_until_beats(4, 10, "starved");
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 3), 32'(32'h30 + i)}) bad++;
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL starved_order: %0d bad beats required 0", bad);
    end
    wait_idle(10, "starved");
  endtask

  task automatic test_back_to_back();
    logic [6:0] vpat;
    logic       rdy2, rd2;
    int         bad;
    beats.delete();
    for (int i = 0; i < 5; i++) fq.push_back(32'h20 + i);
    drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd1; w_ready_i = 1'b1;
    cycle();
    cmd_len_i = 8'd2;
    rdy2 = 1'b0; rd2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      vpat[i] = s_valid;
      if (i == 1) begin
        rdy2 = s_cmd_ready; rd2 = s_rd_en;
        cmd_valid_i = 1'b0;
      end
    end
    vectors++;
    if (rdy2 !== 1'b1 || rd2 !== 1'b1) begin
      errors++; $display("FAIL b2b_chain_accept: rdy=%b rd=%b required 1 1", rdy2, rd2);
    end
    vectors++;
    if (vpat !== 7'b0111110) begin
      errors++; $display("FAIL b2b_valid_pattern: got %b required 0111110", vpat);
    end
    vectors++;
    if (beats.size() !== 5) begin
      errors++; $display("FAIL b2b_beat_count: got %0d required 5", beats.size());
    end
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 1 || i == 4), 32'(32'h20 + i)}) bad++;
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_order: %0d bad beats required 0", bad);
    end
    wait_idle(10, "b2b");
  endtask

  task automatic test_max_len();
    int p0;
    int bad;
    beats.delete();
    for (int i = 0; i < 258; i++) fq.push_back(32'h1000 + i);
    drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd255; w_ready_i = 1'b1;
    p0 = pops;
    cycle();
    cmd_valid_i = 1'b0;
    run_until_beats(256, 400, "maxlen");
    for (int i = 0; i < 5; i++) cycle();
    vectors++;
    if (beats.size() !== 256 || pops - p0 !== 256 || fq.size() !== 2) begin
      errors++;
      $display("FAIL maxlen_no_wrap: beats=%0d pops=%0d left=%0d required 256 256 2",
               beats.size(), pops - p0, fq.size());
    end
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 255), 32'(32'h1000 + i)}) bad++;
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL maxlen_order: %0d bad beats required 0", bad);
    end
    vectors++;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL maxlen_idle: busy=%b required 0", s_busy);
    end
    fq.delete(); drive_fifo();
  endtask

  task automatic test_reset_mid_burst();
    beats.delete();
    for (int i = 0; i < 8; i++) fq.push_back(32'h40 + i);
    drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd7; w_ready_i = 1'b1;
    cycle();
    cmd_valid_i = 1'b0;
    run_until_beats(2, 10, "midrst");
    rst_n = 1'b0; fq.delete(); drive_fifo();
    cycle();
    vectors++;
    if (s_cmd_ready !== 1'b0 || s_rd_en !== 1'b0) begin
      errors++; $display("FAIL midrst_gated: rdy=%b rd=%b required 0 0", s_cmd_ready, s_rd_en);
    end
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (s_valid !== 1'b0 || s_cmd_ready !== 1'b1 || s_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_cleared: v=%b rdy=%b b=%b required 0 1 0", s_valid, s_cmd_ready, s_busy);
    end
    beats.delete();
    fq.push_back(32'h99); drive_fifo();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd0;
    cycle();
    cmd_valid_i = 1'b0;
    run_until_beats(1, 10, "midrst_fresh");
    vectors++;
    if (beats.size() == 1 && beats[0] !== {1'b1, 32'h99}) begin
      errors++; $display("FAIL midrst_fresh_beat: got %h required 100000099", beats[0]);
    end
    wait_idle(10, "midrst");
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0; w_ready_i = 1'b0;
    drive_fifo();
    test_reset();
    test_single();
    test_backpressure();
    test_starved();
    test_back_to_back();
    test_max_len();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
